// File: rtl/pulse_hist_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_hist_gen_if
//  Purpose  : Bundles the two single-port BRAM ports (pin marker BRAM and
//             pulse histogram BRAM) driven by pulse_hist_gen.
//  Ports    : pin_addr/pin_din/pin_we/pin_en   - pin BRAM (write only)
//             pul_addr/pul_din/pul_we/pul_en   - pulse BRAM request side
//             pul_dout                         - pulse BRAM read data
//  Modports : master - generator side, slave - BRAM side
//  Revision : 1.0  initial release
// ============================================================================
interface pulse_hist_gen_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       pin_addr;
   logic [DATA_W-1:0] pin_din;
   logic              pin_we;
   logic              pin_en;
   logic [31:0]       pul_addr;
   logic [DATA_W-1:0] pul_din;
   logic              pul_we;
   logic              pul_en;
   logic [DATA_W-1:0] pul_dout;

   modport master (
      output pin_addr, pin_din, pin_we, pin_en,
      output pul_addr, pul_din, pul_we, pul_en,
      input  pul_dout
   );

   modport slave (
      input  pin_addr, pin_din, pin_we, pin_en,
      input  pul_addr, pul_din, pul_we, pul_en,
      output pul_dout
   );
endinterface
`default_nettype wire

// File: rtl/pulse_hist_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_hist_gen
//  Purpose  : Per event, draws a bin from a Fibonacci LFSR, marks it in the
//             pin BRAM and increments PULSE_LEN consecutive bins of the pulse
//             BRAM (saturating read-modify-write), repeating cps times.
//  Ports    : clk, rst        - clock / asynchronous active-high reset
//             cps             - events requested (0 = idle, change = restart)
//             bram            - pin/pulse BRAM ports (master modport)
//             busy            - event sequence in progress
//             done            - cps events completed
//             evt_cnt         - events completed since last start
//  Revision : 1.0  initial release
// ============================================================================
module pulse_hist_gen #(
   parameter int               ADDR_W    = 10,
   parameter int               DATA_W    = 32,
   parameter int               PULSE_LEN = 6,
   parameter int               RD_LAT    = 1,
   parameter logic [ADDR_W-1:0] LFSR_SEED = 10'h2AA,
   parameter logic [ADDR_W-1:0] LFSR_TAPS = 10'h240
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic [31:0]  cps,
   pulse_hist_gen_if.master  bram,
   output logic              busy,
   output logic              done,
   output logic [31:0]       evt_cnt
);

   localparam logic [2:0] c_s_idle  = 3'd0;
   localparam logic [2:0] c_s_start = 3'd1;
   localparam logic [2:0] c_s_rd    = 3'd2;
   localparam logic [2:0] c_s_wait  = 3'd3;
   localparam logic [2:0] c_s_wr    = 3'd4;
   localparam logic [2:0] c_s_done  = 3'd5;

   localparam int               c_k_w       = ADDR_W + 1;
   localparam logic [c_k_w-1:0] c_k_last    = c_k_w'(PULSE_LEN - 1);
   localparam logic [2:0]       c_wait_last = 3'(RD_LAT - 1);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_lfsr;
   logic [ADDR_W-1:0] r_base;
   logic [c_k_w-1:0]  r_k;
   logic [2:0]        r_wait;
   logic [31:0]       r_prev_cps;
   logic [31:0]       r_evt_cnt;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_fb;
   logic [ADDR_W-1:0] w_lfsr_raw;
   logic [ADDR_W-1:0] w_lfsr_nxt;
   logic [ADDR_W-1:0] w_bin;
   logic [31:0]       w_pul_addr;
   logic              w_clear;

   assign w_fb       = ^(r_lfsr & LFSR_TAPS);
   assign w_lfsr_raw = {r_lfsr[ADDR_W-2:0], w_fb};
   // An all-zero LFSR would lock up; fall back to the seed instead.
   assign w_lfsr_nxt = (w_lfsr_raw == '0) ? LFSR_SEED : w_lfsr_raw;

   // Natural ADDR_W-bit addition gives the modulo-2^ADDR_W bin wrap.
   assign w_bin      = r_base + r_k[ADDR_W-1:0];
   assign w_pul_addr = 32'({w_bin, 2'b00});

   // A changed request, or no request, aborts whatever is in flight.
   assign w_clear    = (cps != r_prev_cps) || (cps == 32'd0);

   assign evt_cnt    = r_evt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_s_idle;
         r_lfsr     <= LFSR_SEED;
         r_base     <= '0;
         r_k        <= '0;
         r_wait     <= '0;
         r_prev_cps <= '0;
         r_evt_cnt  <= '0;
         r_rd_data  <= '0;
      end else if (w_clear) begin
         r_state    <= c_s_idle;
         r_lfsr     <= LFSR_SEED;
         r_k        <= '0;
         r_wait     <= '0;
         r_prev_cps <= cps;
         r_evt_cnt  <= '0;
      end else begin
         case (r_state)
            c_s_idle: begin
               r_state <= c_s_start;
            end
            c_s_start: begin
               r_base  <= r_lfsr;
               r_k     <= '0;
               r_lfsr  <= w_lfsr_nxt;
               r_state <= c_s_rd;
            end
            c_s_rd: begin
               r_wait  <= '0;
               r_state <= c_s_wait;
            end
            c_s_wait: begin
               // Capture read data in the cycle it becomes valid so WR does
               // not depend on the BRAM holding its output.
               if (r_wait == c_wait_last) begin
                  r_rd_data <= bram.pul_dout;
                  r_state   <= c_s_wr;
               end else begin
                  r_wait <= r_wait + 3'd1;
               end
            end
            c_s_wr: begin
               if (r_k != c_k_last) begin
                  r_k     <= r_k + c_k_w'(1);
                  r_state <= c_s_rd;
               end else begin
                  r_evt_cnt <= r_evt_cnt + 32'd1;
                  r_state   <= (r_evt_cnt + 32'd1 == cps) ? c_s_done : c_s_start;
               end
            end
            c_s_done: begin
               r_state <= c_s_done;
            end
            default: begin
               r_state <= c_s_idle;
            end
         endcase
      end
   end

   // Outputs decode the state register directly, so an asynchronous reset
   // forces every enable low immediately.
   always_comb begin
      bram.pin_addr = '0;
      bram.pin_din  = '0;
      bram.pin_we   = 1'b0;
      bram.pin_en   = 1'b0;
      bram.pul_addr = '0;
      bram.pul_din  = '0;
      bram.pul_we   = 1'b0;
      bram.pul_en   = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (r_state)
         c_s_start: begin
            bram.pin_en   = 1'b1;
            bram.pin_we   = 1'b1;
            bram.pin_addr = 32'({r_lfsr, 2'b00});
            bram.pin_din  = DATA_W'(1);
            busy          = 1'b1;
         end
         c_s_rd: begin
            bram.pul_en   = 1'b1;
            bram.pul_addr = w_pul_addr;
            busy          = 1'b1;
         end
         c_s_wait: begin
            busy = 1'b1;
         end
         c_s_wr: begin
            bram.pul_en   = 1'b1;
            bram.pul_we   = 1'b1;
            bram.pul_addr = w_pul_addr;
            bram.pul_din  = (r_rd_data == '1) ? r_rd_data : r_rd_data + DATA_W'(1);
            busy          = 1'b1;
         end
         c_s_done: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
